toggle_event_decoder: RTL and testbench
=======================================

Name: toggle_event_decoder

Overview:
- Receive end of the toggle-event protocol: the transmitter's T flip-flop flips its Q line once per event; this block recovers each level change as one event.
- Synchronises the toggle line into Clk and emits a one-cycle recovered-T pulse per change.
- Queues pending events in a saturating counter, drained by a valid/ack handshake to the consumer.

Parameters:
- SYNC_STAGES, 2, synchroniser flops on Q_in (legal values: 2 or more).
- CNT_W, 4, pending-counter width; maximum pending count is 2^CNT_W-1.

Ports:
- Clk  input  1  system clock; all logic updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- Q_in  input  1  toggle line from the remote T flip-flop; may be asynchronous to Clk.
- ack  input  1  consumer accepts one event; only meaningful while evt_valid=1.
- T_pulse  output  1  recovered T: one-cycle pulse per accepted Q_in change.
- level  output  1  synchronised Q_in level.
- evt_valid  output  1  high when evt_count != 0.
- evt_count  output  CNT_W  number of pending events.
- overflow  output  1  sticky flag: an event was dropped at saturation.

Behaviour:
- Reset: rst is synchronous, active-high; the single clock is Clk.
  - While rst=1 on an edge: T_pulse=0, evt_count=0, evt_valid=0, overflow=0, state=IDLE.
  - The sync chain is not reset and keeps sampling.
  - The edge-detect register prev loads the sync output, so no spurious event appears at reset release.
  - rst must be held for at least SYNC_STAGES+1 cycles.
  - level is not reset; it always equals the last sync stage.
- Edge detect: edge = sync_out XOR prev; prev <= sync_out each cycle.
- Latency: a Q_in change sampled at edge n raises T_pulse and increments evt_count at edge n+SYNC_STAGES+1.
- A change that reverts before being sampled is lost. Two sampled changes on consecutive cycles give two pulses.
- Counter update per cycle, with pop = evt_valid AND ack:
  - edge without pop: +1.
  - pop without edge: -1.
  - edge with pop: unchanged. T_pulse still fires and the event is counted as accepted.
  - ack while evt_count=0: ignored; the count never underflows.
- Saturation: an edge while evt_count=2^CNT_W-1 without pop is dropped.
  - evt_count holds; overflow sets and stays set until rst.
  - T_pulse still fires, because it reflects the line, not the queue.
- FSM, with state registered alongside evt_count:
  - IDLE (count 0) -> PEND on edge without pop.
  - PEND -> IDLE when count=1 and pop without edge.
  - PEND -> SAT when count reaches maximum.
  - SAT -> PEND on pop without edge.
  - SAT stays SAT on an edge (drop, set overflow).
  - SAT with edge and pop together: stays SAT, no drop.
- evt_valid is a registered output derived from the state: state != IDLE.
- rst mid-operation: pending events are discarded; a Q_in change in flight during reset is absorbed into prev, not counted.

Optional Feature:
- Macro: TOGGLE_DEC_FILTER_EN.
- Defined: a glitch filter after the sync chain. The filtered level updates only when the sync output has held the same value for 2 consecutive cycles.
  - Edge detect, T_pulse and level use the filtered level.
  - Latency becomes SYNC_STAGES+2 cycles.
  - A one-cycle sync pulse produces no event.
  - The filter register also baselines during rst.
- Undefined: no filter; behaviour and latency exactly as above.

Decomposition:
- Package toggle_dec_pkg:
  - FSM state enum {IDLE, PEND, SAT}.
  - Default constants TOGGLE_SYNC_STAGES_DEF=2 and TOGGLE_CNT_W_DEF=4.
- Sub-module toggle_sync: SYNC_STAGES-deep flop chain with no reset, input d, output q. It is reused by other CDC inputs.
- The counter, FSM and filter stay in the top module.

Test Plan:
1. rst=1 for 4 cycles with Q_in=1, then release and hold Q_in=1 -> T_pulse never fires; evt_count=0, evt_valid=0, level=1.
2. Q_in toggles 0->1 at t=22 (Clk period 10, rising edges at 5,15,...) -> T_pulse high for exactly one cycle, 3 edges after first sampling (edge at t=55); evt_count=1, evt_valid=1.
3. Five Q_in changes spaced 20 time units apart with ack=0 -> five T_pulses; evt_count steps 1..5; then hold ack=1 for 5 cycles -> count 4,3,2,1,0 and evt_valid drops after the last pop.
4. 16 changes with ack=0 (CNT_W=4) -> evt_count saturates at 15; the 16th change still pulses T_pulse, sets overflow, and the count stays 15. Overflow stays set after draining to 0 and clears only on rst.
5. An edge coincident with ack at evt_count=3 -> evt_count stays 3 and T_pulse=1. A separate ack at evt_count=0 -> no change.
6. With TOGGLE_DEC_FILTER_EN: a 1-cycle Q_in glitch 0->1->0 -> no T_pulse, count unchanged. A stable change -> T_pulse at SYNC_STAGES+2 cycles.

Source files
------------

// File: rtl/toggle_dec_pkg.sv
// Shared types and defaults for the toggle-event receive path.
//   toggle_state_e           : pending-queue state (IDLE / PEND / SAT)
//   TOGGLE_SYNC_STAGES_DEF   : default synchroniser depth
//   TOGGLE_CNT_W_DEF         : default pending-counter width
package toggle_dec_pkg;

  localparam int TOGGLE_SYNC_STAGES_DEF = 2;
  localparam int TOGGLE_CNT_W_DEF       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    SAT  = 2'd2
  } toggle_state_e;

endpackage

// File: rtl/toggle_sync.sv
// Plain multi-flop synchroniser for a single-bit asynchronous input.
// No reset: the chain always samples, so it is already settled when any
// downstream reset is released.
// Ports:
//   clk : destination clock
//   d   : asynchronous input
//   q   : synchronised output (last stage)
module toggle_sync
  import toggle_dec_pkg::*;
#(
  parameter int SYNC_STAGES = TOGGLE_SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic d,
  output logic q
);

  logic stage_q [SYNC_STAGES];

  always_ff @(posedge clk) begin
    stage_q[0] <= d;
  end

  generate
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_stage
      always_ff @(posedge clk) begin
        stage_q[gi] <= stage_q[gi-1];
      end
    end
  endgenerate

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/toggle_event_decoder.sv
// Receive side of the toggle-event protocol: every level change on Q_in is
// recovered as one event, pulsed on T_pulse and queued in a saturating
// pending counter that the consumer drains with evt_valid/ack.
// Optional build macro TOGGLE_DEC_FILTER_EN adds a two-cycle glitch filter
// after the synchroniser (one extra cycle of latency).
// Ports:
//   Clk       : system clock (rising edge)
//   rst       : synchronous active-high reset
//   Q_in      : toggle line, asynchronous to Clk
//   ack       : consumer takes one event while evt_valid=1
//   T_pulse   : one-cycle pulse per recovered change
//   level     : synchronised (or filtered) line level
//   evt_valid : events pending
//   evt_count : number of pending events
//   overflow  : sticky, an event was dropped at saturation
module toggle_event_decoder
  import toggle_dec_pkg::*;
#(
  parameter int SYNC_STAGES = TOGGLE_SYNC_STAGES_DEF,
  parameter int CNT_W       = TOGGLE_CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             Q_in,
  input  logic             ack,
  output logic             T_pulse,
  output logic             level,
  output logic             evt_valid,
  output logic [CNT_W-1:0] evt_count,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic sync_out;

  toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (Clk),
    .d   (Q_in),
    .q   (sync_out)
  );

  // lvl_q is the level fed to the edge detector; it sits one register
  // after the sync chain, which gives the SYNC_STAGES+1 event latency.
  logic lvl_q;
  logic prev_q;

`ifdef TOGGLE_DEC_FILTER_EN
  logic hold_q;

  // Accept a new level only once sync_out has shown it on two consecutive
  // cycles; during rst the filter simply tracks the line as a baseline.
  always_ff @(posedge Clk) begin
    hold_q <= sync_out;
    if (rst || (sync_out == hold_q)) begin
      lvl_q <= sync_out;
    end
  end

  assign level = lvl_q;
`else
  always_ff @(posedge Clk) begin
    lvl_q <= sync_out;
  end

  assign level = sync_out;
`endif

  logic edge_det;
  assign edge_det = lvl_q ^ prev_q;

  toggle_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             valid_q;
  logic             t_pulse_q;
  logic             pop;

  assign pop = valid_q & ack;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (edge_det && !pop) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_d == CNT_MAX) ? SAT : PEND;
        end
      end
      PEND: begin
        if (edge_det && !pop) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_MAX) state_d = SAT;
        end else if (pop && !edge_det) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_ONE) state_d = IDLE;
        end
      end
      SAT: begin
        // Edge with simultaneous pop is an accepted event: no drop.
        if (edge_det && !pop) begin
          ovf_d = 1'b1;
        end else if (pop && !edge_det) begin
          cnt_d   = cnt_q - 1'b1;
          state_d = (cnt_d == '0) ? IDLE : PEND;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
      t_pulse_q <= 1'b0;
      // Baseline against the synchroniser so a change in flight during
      // reset is absorbed rather than counted.
      prev_q    <= sync_out;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      valid_q   <= (state_d != IDLE);
      t_pulse_q <= edge_det;
      prev_q    <= lvl_q;
    end
  end

  assign T_pulse   = t_pulse_q;
  assign evt_valid = valid_q;
  assign evt_count = cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Scoreboard bench for toggle_event_decoder: every stimulated Q_in change
// pushes the expected pulse cycle, count and overflow; a monitor pops one
// entry per observed T_pulse.
module tb_toggle_event_decoder;

`ifdef TOGGLE_DEC_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic       Clk = 1'b0;
  logic       rst = 1'b1;
  logic       Q_in = 1'b1;
  logic       ack = 1'b0;
  logic       T_pulse;
  logic       level;
  logic       evt_valid;
  logic [3:0] evt_count;
  logic       overflow;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int cyc;
    int cnt;
    bit ovf;
  } exp_t;

  exp_t sb_q[$];

  toggle_event_decoder #(.SYNC_STAGES(2), .CNT_W(4)) dut (
    .Clk       (Clk),
    .rst       (rst),
    .Q_in      (Q_in),
    .ack       (ack),
    .T_pulse   (T_pulse),
    .level     (level),
    .evt_valid (evt_valid),
    .evt_count (evt_count),
    .overflow  (overflow)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
  endtask

  // Call right after a negedge: the change is sampled on the next posedge.
  task automatic toggle(input int ecnt, input bit eovf);
    exp_t e;
    Q_in  = ~Q_in;
    e.cyc = cyc + 1 + LAT;
    e.cnt = ecnt;
    e.ovf = eovf;
    sb_q.push_back(e);
  endtask

  always @(negedge Clk) begin
    if (T_pulse) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: T_pulse=1 with no pending change (cyc %0d count %0d)",
                 cyc, evt_count);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("pulse cyc=%0d count=%0d ovf=%0d", cyc, evt_count, overflow);
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_count", int'(evt_count), e.cnt);
        chk("pulse_ovf", int'(overflow), int'(e.ovf));
        chk("pulse_valid", int'(evt_valid), int'(e.cnt != 0));
      end
    end
  end

  initial begin
    // 1: reset with Q_in=1
    repeat (4) tick();
    chk("rst_count", int'(evt_count), 0);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_pulse", int'(T_pulse), 0);
    rst = 1'b0;
    repeat (6) tick();
    chk("post_rst_count", int'(evt_count), 0);
    chk("post_rst_valid", int'(evt_valid), 0);
    chk("post_rst_level", int'(level), 1);

    // 2: single change
    toggle(1, 0);
    repeat (LAT + 2) tick();
    chk("single_count", int'(evt_count), 1);
    chk("single_valid", int'(evt_valid), 1);
    chk("single_level", int'(level), int'(Q_in));

    // 3: four more changes, then drain five
    for (int i = 2; i <= 5; i++) begin
      toggle(i, 0);
      repeat (2) tick();
    end
    repeat (LAT + 2) tick();
    chk("five_count", int'(evt_count), 5);
    ack = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      tick();
      chk("drain_count", int'(evt_count), i);
    end
    ack = 1'b0;
    chk("drain_valid", int'(evt_valid), 0);

    // 5b: ack while empty
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    chk("ack_empty_count", int'(evt_count), 0);
    chk("ack_empty_valid", int'(evt_valid), 0);

`ifdef TOGGLE_DEC_FILTER_EN
    // 6: one-cycle glitch is filtered, then a stable change counts
    Q_in = ~Q_in;
    tick();
    Q_in = ~Q_in;
    repeat (LAT + 3) tick();
    chk("glitch_count", int'(evt_count), 0);
    toggle(1, 0);
    repeat (LAT + 2) tick();
    chk("filt_count", int'(evt_count), 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
`else
    // back-to-back changes on consecutive cycles give two pulses
    toggle(1, 0);
    tick();
    toggle(2, 0);
    repeat (LAT + 2) tick();
    chk("b2b_count", int'(evt_count), 2);
    ack = 1'b1;
    repeat (2) tick();
    ack = 1'b0;
`endif
    chk("drained_count", int'(evt_count), 0);

    // 5a: edge coincident with ack at count 3
    for (int i = 1; i <= 3; i++) begin
      toggle(i, 0);
      repeat (2) tick();
    end
    repeat (LAT + 2) tick();
    chk("three_count", int'(evt_count), 3);
    toggle(3, 0);
    repeat (LAT) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    chk("coinc_count", int'(evt_count), 3);
    ack = 1'b1;
    repeat (3) tick();
    ack = 1'b0;
    chk("coinc_drain", int'(evt_count), 0);

    // 4: saturation and sticky overflow
    for (int i = 1; i <= 16; i++) begin
      toggle((i > 15) ? 15 : i, (i > 15));
      repeat (2) tick();
    end
    repeat (LAT + 2) tick();
    chk("sat_count", int'(evt_count), 15);
    chk("sat_ovf", int'(overflow), 1);
    ack = 1'b1;
    repeat (15) tick();
    ack = 1'b0;
    tick();
    chk("sat_drain_count", int'(evt_count), 0);
    chk("sat_drain_valid", int'(evt_valid), 0);
    chk("ovf_sticky", int'(overflow), 1);
    rst = 1'b1;
    repeat (4) tick();
    rst = 1'b0;
    tick();
    chk("ovf_cleared", int'(overflow), 0);

    // reset mid-operation: pending discarded, in-flight change absorbed
    toggle(1, 0);
    repeat (LAT + 2) tick();
    chk("mid_pre_count", int'(evt_count), 1);
    Q_in = ~Q_in;
    tick();
    rst = 1'b1;
    repeat (4) tick();
    rst = 1'b0;
    repeat (LAT + 3) tick();
    chk("mid_rst_count", int'(evt_count), 0);
    chk("mid_rst_valid", int'(evt_valid), 0);
    chk("mid_rst_level", int'(level), int'(Q_in));

    chk("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
